cmdspi_bus_arb: RTL
===================

Name: cmdspi_bus_arb

Overview:
- Sequences register accesses on the shared 128 x 32 control register bus.
- Two requesters share the bus:
  - the cmdspi slave: 40-bit frame of command byte {rw, addr[6:0]} followed by 32 data bits;
  - the on-chip DSP core.
- Prefetches SPI reads so read data is ready before the slave shifts it out.
- Issues SPI writes when the frame completes.
- Bounds every bus access with a timeout.

Parameters:
- AW, 7, register address width.
- DW, 32, data width.
- TIMEOUT, 15, clk cycles to wait for bus_ack before aborting; must be at least 1.
- TO_DATA, 32'hDEADBEEF, read data returned on a timed-out read.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_addr_vld  in  1  one-cycle pulse: slave has latched the command byte.
- spi_rw  in  1  command bit 7, 1=write; valid with spi_addr_vld.
- spi_addr  in  AW  command address; valid with spi_addr_vld.
- spi_we  in  1  one-cycle pulse: write frame data complete.
- spi_wdat  in  DW  write data; valid with spi_we.
- spi_rdat  out  DW  read data to slave rdat.
- spi_rdat_vld  out  1  spi_rdat holds data for the current frame.
- core_req  in  1  core request; held until granted.
- core_we  in  1  core write enable.
- core_addr  in  AW  core address.
- core_wdat  in  DW  core write data.
- core_gnt  out  1  one-cycle pulse: request captured.
- core_done  out  1  one-cycle pulse: access finished.
- core_rdat  out  DW  read data; valid with core_done.
- bus_req  out  1  bus access strobe; held until ack or timeout.
- bus_we  out  1  bus write enable.
- bus_addr  out  AW  bus address.
- bus_wdat  out  DW  bus write data.
- bus_ack  in  1  one-cycle completion from the register bus.
- bus_rdat  in  DW  read data; valid with bus_ack.
- bus_timeout  out  1  one-cycle pulse on abort.
- err_cnt  out  8  timeout count; saturates at 255.

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE; pending flags clear.
  - Async assertion mid-access drops bus_req immediately.
  - No completion pulses are emitted for the aborted access.
- SPI capture:
  - spi_addr_vld with rw=0: latch addr, set rd_pend, clear spi_rdat_vld.
  - spi_addr_vld with rw=1: latch addr only; clear spi_rdat_vld.
  - spi_we: latch spi_wdat and set wr_pend, using the latched addr.
  - spi_addr_vld while rd_pend is not yet issued: the new frame overwrites the pending read.
- FSM states are IDLE, ACCESS, DONE.
- IDLE, checked in priority order:
  - wr_pend: issue SPI write. The write precedes any later read, preserving frame order.
  - rd_pend: issue SPI read.
  - core_req: capture we/addr/wdat, pulse core_gnt, issue.
  - An issue drives bus_req/we/addr/wdat registered, clears the corresponding pend flag, loads the timer, and moves to ACCESS.
- ACCESS:
  - bus_req and its fields are held stable.
  - On bus_ack: route the result and go to DONE.
  - If the timer expires after TIMEOUT cycles with no ack: drop bus_req, pulse bus_timeout, increment err_cnt, use TO_DATA as read data, go to DONE.
  - bus_ack in the expiry cycle counts as an ack, not a timeout.
- DONE: deassert bus_req for one cycle, then return to IDLE. This guarantees at least one idle bus cycle between accesses.
- Routing, registered on the ack/timeout edge:
  - SPI read: spi_rdat <= data, spi_rdat_vld <= 1.
  - SPI write: no data update.
  - Core access: core_rdat <= data for reads (unchanged for writes); pulse core_done.
- SPI has fixed priority; accesses are non-preemptive. A core access in flight completes before the SPI request is served.
- Worst-case SPI read latency from spi_addr_vld to spi_rdat_vld is 2*(TIMEOUT+2)+1 clk. Integration must ensure this is less than 1 SCLK period times the slave's first-bit setup.

Decomposition:
- Package cmdspi_pkg holds:
  - AW and DW constants;
  - FSM state encoding (IDLE/ACCESS/DONE);
  - owner encoding (SPI_RD/SPI_WR/CORE);
  - TO_DATA default.
- Sub-module cmdspi_bus_timer: loadable down-counter with an expire flag, sized by $clog2(TIMEOUT+1).

Test Plan:
- SPI read: spi_addr_vld, rw=0, addr=0x12; ack 3 cycles later with 0xA5A5A5A5 -> bus_req rises the next cycle with we=0, addr=0x12; spi_rdat=0xA5A5A5A5 and spi_rdat_vld=1 one cycle after ack.
- SPI write: addr_vld rw=1 addr=0x02, then spi_we wdat=0x12345678 -> no bus access at addr_vld; bus_we=1, addr=0x02, wdat=0x12345678 after spi_we.
- Contention: core_req addr=0x05 in the same cycle rd_pend sets -> SPI access first; core_gnt in the IDLE cycle after SPI DONE; core_done follows its ack.
- Core in flight when spi_addr_vld arrives -> core completes; SPI bus_req asserts 2 cycles after the core ack.
- Timeout: no ack, TIMEOUT=15 -> bus_req high for exactly 15 cycles; bus_timeout pulse; spi_rdat=0xDEADBEEF; err_cnt=1. After 256 timeouts err_cnt=255.
- Reset: rst_n low while bus_req=1 -> all outputs 0 in the same cycle. After release, no core_done or spi_rdat_vld pulse and no stale access.

Source files
------------

// File: rtl/cmdspi_pkg.sv
// Shared types and constants for the cmdspi register-bus arbiter.
package cmdspi_pkg;

    localparam int          CMDSPI_AW      = 7;
    localparam int          CMDSPI_DW      = 32;
    localparam logic [31:0] CMDSPI_TO_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_SPI_RD = 2'd0,
        OWN_SPI_WR = 2'd1,
        OWN_CORE   = 2'd2
    } owner_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmdspi_bus_timer.sv
// Loadable down-counter bounding one bus access; expire_o flags the last
// allowed cycle while counting is enabled.
module cmdspi_bus_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= TW'(TIMEOUT);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign expire_o = en_i && (cnt_q == TW'(1));

endmodule

// File: rtl/cmdspi_bus_arb.sv
// Arbitrates the shared control-register bus between the cmdspi slave
// (prefetched reads, frame-complete writes) and the DSP core, with a timeout.
module cmdspi_bus_arb
    import cmdspi_pkg::*;
#(
    parameter int            AW      = CMDSPI_AW,
    parameter int            DW      = CMDSPI_DW,
    parameter int            TIMEOUT = 15,
    parameter logic [DW-1:0] TO_DATA = DW'(CMDSPI_TO_DATA)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_addr_vld,
    input  logic          spi_rw,
    input  logic [AW-1:0] spi_addr,
    input  logic          spi_we,
    input  logic [DW-1:0] spi_wdat,
    output logic [DW-1:0] spi_rdat,
    output logic          spi_rdat_vld,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdat,
    output logic          core_gnt,
    output logic          core_done,
    output logic [DW-1:0] core_rdat,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdat,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdat,
    output logic          bus_timeout,
    output logic [7:0]    err_cnt
);
    state_e        state_q;
    owner_e        owner_q;
    logic [AW-1:0] spi_addr_q, wr_addr_q;
    logic [DW-1:0] wr_dat_q;
    logic          rd_pend_q, wr_pend_q, rd_stale_q;

    logic          bus_req_q, bus_we_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_wdat_q, core_rdat_q, spi_rdat_q;
    logic          core_gnt_q, core_done_q, spi_rdat_vld_q, bus_timeout_q;
    logic [7:0]    err_cnt_q;

    logic          issue_d, finish_d, tmr_expire;
    logic [DW-1:0] result_d;

    assign issue_d  = (state_q == ST_IDLE) && (wr_pend_q || rd_pend_q || core_req);
    // An ack arriving in the expiry cycle wins over the timeout.
    assign finish_d = (state_q == ST_ACCESS) && (bus_ack || tmr_expire);
    assign result_d = bus_ack ? bus_rdat : TO_DATA;

    cmdspi_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .load_i   (issue_d),
        .en_i     (state_q == ST_ACCESS),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_CORE;
            spi_addr_q     <= '0;
            wr_addr_q      <= '0;
            wr_dat_q       <= '0;
            rd_pend_q      <= 1'b0;
            wr_pend_q      <= 1'b0;
            rd_stale_q     <= 1'b0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdat_q     <= '0;
            core_gnt_q     <= 1'b0;
            core_done_q    <= 1'b0;
            core_rdat_q    <= '0;
            spi_rdat_q     <= '0;
            spi_rdat_vld_q <= 1'b0;
            bus_timeout_q  <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            core_gnt_q    <= 1'b0;
            core_done_q   <= 1'b0;
            bus_timeout_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Pending write goes first so an earlier frame's write lands before a later read.
                    if (wr_pend_q) begin
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b1;
                        bus_addr_q <= wr_addr_q;
                        bus_wdat_q <= wr_dat_q;
                        owner_q    <= OWN_SPI_WR;
                        wr_pend_q  <= 1'b0;
                        state_q    <= ST_ACCESS;
                    end else if (rd_pend_q) begin
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= spi_addr_q;
                        bus_wdat_q <= '0;
                        owner_q    <= OWN_SPI_RD;
                        rd_pend_q  <= 1'b0;
                        rd_stale_q <= 1'b0;
                        state_q    <= ST_ACCESS;
                    end else if (core_req) begin
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= core_we;
                        bus_addr_q <= core_addr;
                        bus_wdat_q <= core_wdat;
                        owner_q    <= OWN_CORE;
                        core_gnt_q <= 1'b1;
                        state_q    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (finish_d) begin
                        bus_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        if (!bus_ack) begin
                            bus_timeout_q <= 1'b1;
                            err_cnt_q     <= sat_inc8(err_cnt_q);
                        end
                        case (owner_q)
                            OWN_SPI_RD: begin
                                if (!rd_stale_q) begin
                                    spi_rdat_q     <= result_d;
                                    spi_rdat_vld_q <= 1'b1;
                                end
                            end
                            OWN_CORE: begin
                                if (!bus_we_q) core_rdat_q <= result_d;
                                core_done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            // Frame capture comes last so a new frame overrides same-cycle issue/completion.
            if (spi_addr_vld) begin
                spi_addr_q     <= spi_addr;
                rd_pend_q      <= ~spi_rw;
                spi_rdat_vld_q <= 1'b0;
                rd_stale_q     <= 1'b1;
            end
            if (spi_we) begin
                wr_addr_q <= spi_addr_q;
                wr_dat_q  <= spi_wdat;
                wr_pend_q <= 1'b1;
            end
        end
    end

    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdat     = bus_wdat_q;
    assign core_gnt     = core_gnt_q;
    assign core_done    = core_done_q;
    assign core_rdat    = core_rdat_q;
    assign spi_rdat     = spi_rdat_q;
    assign spi_rdat_vld = spi_rdat_vld_q;
    assign bus_timeout  = bus_timeout_q;
    assign err_cnt      = err_cnt_q;

endmodule
